cordic_polar2rect: RTL and testbench
====================================

// Module: cordic_polar2rect
// PURPOSE
//  Iterative (one micro-rotation per clock) CORDIC rotation engine: converts polar (r, angle)
//  as produced by the vectoring path back into rectangular (x, y). It is the return leg of the
//  rect->polar datapath, using the same centidegree angle format (4500 = 45.00 deg) and the
//  same 607/1000 gain correction. It has valid/ready handshakes on both sides.
// PARAMETERS
//  W     16  data width of r_in, x_out, y_out (signed); internal x/y datapath is W+2 bits
//  ITER  8   micro-rotations per conversion, legal 1..8; atan table limits this to 8
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  reset, asynchronous, active-high
//  in_valid   in   1  r_in/ang_in valid
//  in_ready   out  1  block can accept a new operand
//  r_in       in   W  signed magnitude
//  ang_in     in   16 signed angle, centidegrees
//  out_valid  out  1  x_out/y_out valid
//  out_ready  in   1  consumer accepts result
//  x_out      out  W  signed r*cos(ang)
//  y_out      out  W  signed r*sin(ang)
//  ang_err    out  1  present only with CORDIC_ANGERR_EN
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, x_out=y_out=0, ang_err=0, internal regs 0.
//   Reset asserted in any state aborts the operation; the result is discarded.
//  FSM IDLE->PRE->ROT->SCALE->OUT->IDLE.
//  - IDLE: in_ready=1. When in_valid&&in_ready: latch x=r_in (sign-extended to W+2), y=0,
//    z=ang_in. Go to PRE.
//  - PRE (1 cycle): if z>9000 then x=0, y=r, z-=9000. If z<-9000 then x=0, y=-r, z+=9000.
//    Otherwise x/y/z are unchanged. Set i=0.
//  - ROT (ITER cycles): if z>=0 then x-=y>>>i, y+=x>>>i, z-=ATAN[i]; else the signs are
//    reversed. All three updates use the old x/y values. i++. Leave when i==ITER-1.
//  - SCALE (1 cycle): x_out=(607*x)/1000, y_out=(607*y)/1000. Products are signed, at least
//    28 bits. Division truncates toward zero. The result is saturated to the W-bit range.
//  - OUT: out_valid=1. x_out/y_out stay stable until out_valid&&out_ready, then go to IDLE.
//  - in_ready is 1 only in IDLE; there is no overlap of operations.
//  - Latency: out_valid rises ITER+2 clock edges after the accepting edge.
//    Minimum initiation interval is ITER+4 cycles (out_ready held 1).
//  - ATAN[0..7] = 4500, 2657, 1404, 713, 358, 179, 89, 44.
//    Gain correction is fixed at 607/1000 for any ITER.
// CONFIGURATION
//  CORDIC_ANGERR_EN defined: an input with ang_in outside [-18000, 18000] is accepted
//   normally. The block skips PRE/ROT and delivers x_out=y_out=0 with ang_err=1; ang_err
//   has the same validity and hold rules as out_valid.
//  Undefined: no ang_err port. An out-of-range ang_in is folded once by -/+36000 at latch
//   time, which always lands in range for 16-bit input. It is then processed normally.
// STRUCTURE
//  Package cordic_pkg: ATAN table (8 x 16 bit), K_NUM=607, K_DEN=1000, ANG_90=9000,
//   ANG_180=18000, ANG_360=36000, and the FSM state typedef. The vectoring block reuses
//   these constants.
//  Sub-module cordic_micro_rot (combinational): in x, y, z, shift i, atan -> out x', y', z'.
//   One instance, time-shared across the ROT cycles.
// TESTING (result tolerance: +/-(1% of |r| + 2) LSB)
//  1 r=1000, ang=0 -> x~1000, y~0. out_valid exactly ITER+2 edges after accept.
//  2 r=1000, ang=9000 -> x~0, y~1000. ang=-13500 -> x~-707, y~-707.
//    ang=18000 -> x~-1000, y~0.
//  3 out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, and a new
//    in_valid is not accepted. Release -> IDLE next cycle.
//  4 rst pulse during ROT (i=3) -> out_valid=0 and x/y_out=0 immediately (async). A
//    following op r=500, ang=3000 -> x~433, y~250.
//  5 ang=20000, r=1000: with macro -> x=y=0, ang_err=1. Without -> folded to -16000,
//    giving x~-940, y~-342.
//  6 back-to-back stream with in_valid/out_ready held 1, 20 random ops -> compare each
//    result to a golden model; initiation interval is exactly ITER+4.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and types for the polar<->rect datapaths.
// Angles are signed centidegrees (4500 = 45.00 deg); gain correction is 607/1000.
// Contents: ATAN micro-rotation table, gain constants, angle constants, FSM state type.
package cordic_pkg;

    localparam int unsigned ATAN_N  = 8;
    localparam int unsigned ANG_W   = 16;

    localparam logic signed [31:0] K_NUM = 32'sd607;
    localparam logic signed [31:0] K_DEN = 32'sd1000;

    localparam logic signed [15:0] ANG_90      = 16'sd9000;
    localparam logic signed [15:0] NEG_ANG_90  = -16'sd9000;
    localparam logic signed [15:0] ANG_180     = 16'sd18000;
    localparam logic signed [15:0] NEG_ANG_180 = -16'sd18000;
    // 36000 does not fit a signed 16-bit value, so it lives in 17 bits
    localparam logic signed [16:0] ANG_360     = 17'sd36000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ROT   = 3'd2,
        S_SCALE = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    // atan(2^-i) in centidegrees
    function automatic logic signed [15:0] atan_lut(input logic [2:0] idx);
        case (idx)
            3'd0: return 16'sd4500;
            3'd1: return 16'sd2657;
            3'd2: return 16'sd1404;
            3'd3: return 16'sd713;
            3'd4: return 16'sd358;
            3'd5: return 16'sd179;
            3'd6: return 16'sd89;
            3'd7: return 16'sd44;
        endcase
    endfunction

endpackage

// File: rtl/cordic_polar2rect_if.sv
// Handshake bundle for cordic_polar2rect.
// Input side : in_valid/in_ready, r_in (W, signed), ang_in (16, signed centidegrees)
// Output side: out_valid/out_ready, x_out/y_out (W, signed), ang_err (CORDIC_ANGERR_EN only)
// master = operand producer / result consumer, slave = the CORDIC engine.
interface cordic_polar2rect_if #(
    parameter int unsigned W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  r_in;
    logic signed [15:0]   ang_in;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [W-1:0]  x_out;
    logic signed [W-1:0]  y_out;
`ifdef CORDIC_ANGERR_EN
    logic                 ang_err;
`endif

    modport master (
        output in_valid, output r_in, output ang_in, output out_ready,
        input  in_ready, input out_valid, input x_out, input y_out
`ifdef CORDIC_ANGERR_EN
        , input ang_err
`endif
    );

    modport slave (
        input  in_valid, input r_in, input ang_in, input out_ready,
        output in_ready, output out_valid, output x_out, output y_out
`ifdef CORDIC_ANGERR_EN
        , output ang_err
`endif
    );

endinterface

// File: rtl/cordic_micro_rot.sv
// One CORDIC rotation-mode micro-step (combinational); time-shared by the engine.
// Ports: i_x/i_y (DW signed), i_z (16 signed residual angle), i_shift (step index),
//        i_atan (atan(2^-i) centidegrees) -> o_x/o_y/o_z after the step.
module cordic_micro_rot #(
    parameter int unsigned DW = 18
) (
    input  logic signed [DW-1:0] i_x,
    input  logic signed [DW-1:0] i_y,
    input  logic signed [15:0]   i_z,
    input  logic        [2:0]    i_shift,
    input  logic signed [15:0]   i_atan,
    output logic signed [DW-1:0] o_x,
    output logic signed [DW-1:0] o_y,
    output logic signed [15:0]   o_z
);

    logic signed [DW-1:0] w_xs;
    logic signed [DW-1:0] w_ys;

    assign w_xs = i_x >>> i_shift;
    assign w_ys = i_y >>> i_shift;

    // Rotate toward z=0; both coordinate updates use the pre-step x/y
    always_comb begin
        if (i_z >= 16'sd0) begin
            o_x = i_x - w_ys;
            o_y = i_y + w_xs;
            o_z = i_z - i_atan;
        end else begin
            o_x = i_x + w_ys;
            o_y = i_y - w_xs;
            o_z = i_z + i_atan;
        end
    end

endmodule

// File: rtl/cordic_polar2rect.sv
// Iterative CORDIC polar->rect engine, one micro-rotation per clock.
// Ports: clk, rst (async, active-high), bus (cordic_polar2rect_if.slave):
//   in_valid/in_ready/r_in/ang_in in, out_valid/out_ready/x_out/y_out out.
// Parameters: W data width (internal x/y is W+2), ITER micro-rotations (1..8).
// Optional macro CORDIC_ANGERR_EN: out-of-range angles yield x=y=0 with ang_err=1;
// without it such angles are folded by +/-36000 at latch time.
module cordic_polar2rect
    import cordic_pkg::*;
#(
    parameter int unsigned W    = 16,
    parameter int unsigned ITER = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    cordic_polar2rect_if.slave      bus
);

    localparam int unsigned DW = W + 2;
    localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (W - 1)) - 32'sd1;
    localparam logic signed [31:0] SAT_MIN = -SAT_MAX - 32'sd1;

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic signed [W-1:0]  r_x_out;
    logic signed [W-1:0]  r_y_out;
    logic signed [DW-1:0] r_x;
    logic signed [DW-1:0] r_y;
    logic signed [15:0]   r_z;
    logic        [2:0]    r_i;

    logic signed [DW-1:0] w_rx;
    logic signed [DW-1:0] w_ry;
    logic signed [15:0]   w_rz;
    logic signed [15:0]   w_atan;
    logic signed [31:0]   w_qx;
    logic signed [31:0]   w_qy;

`ifdef CORDIC_ANGERR_EN
    logic                 r_err;
    logic                 r_ang_err;
    logic                 w_ang_bad;

    assign w_ang_bad = (bus.ang_in > ANG_180) || (bus.ang_in < NEG_ANG_180);
    assign bus.ang_err = r_ang_err;
`else
    logic signed [16:0]   w_ang_ext;
    logic signed [15:0]   w_z_fold;

    assign w_ang_ext = 17'(bus.ang_in);

    // A single +/-360 fold always lands in range for a 16-bit angle
    always_comb begin
        w_z_fold = bus.ang_in;
        if (bus.ang_in > ANG_180) begin
            w_z_fold = 16'(w_ang_ext - ANG_360);
        end else if (bus.ang_in < NEG_ANG_180) begin
            w_z_fold = 16'(w_ang_ext + ANG_360);
        end
    end
`endif

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.x_out     = r_x_out;
    assign bus.y_out     = r_y_out;

    assign w_atan = atan_lut(r_i);

    cordic_micro_rot #(.DW(DW)) u_rot (
        .i_x     (r_x),
        .i_y     (r_y),
        .i_z     (r_z),
        .i_shift (r_i),
        .i_atan  (w_atan),
        .o_x     (w_rx),
        .o_y     (w_ry),
        .o_z     (w_rz)
    );

    // Gain correction; signed division truncates toward zero
    assign w_qx = (32'(r_x) * K_NUM) / K_DEN;
    assign w_qy = (32'(r_y) * K_NUM) / K_DEN;

    function automatic logic signed [W-1:0] sat_w(input logic signed [31:0] v);
        if (v > SAT_MAX) return W'(SAT_MAX);
        if (v < SAT_MIN) return W'(SAT_MIN);
        return W'(v);
    endfunction

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_x_out     <= '0;
            r_y_out     <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_i         <= '0;
`ifdef CORDIC_ANGERR_EN
            r_err       <= 1'b0;
            r_ang_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_in_ready <= 1'b0;
                        r_y        <= '0;
`ifdef CORDIC_ANGERR_EN
                        if (w_ang_bad) begin
                            r_x     <= '0;
                            r_z     <= '0;
                            r_err   <= 1'b1;
                            r_state <= S_SCALE;
                        end else begin
                            r_x     <= DW'(bus.r_in);
                            r_z     <= bus.ang_in;
                            r_err   <= 1'b0;
                            r_state <= S_PRE;
                        end
`else
                        r_x     <= DW'(bus.r_in);
                        r_z     <= w_z_fold;
                        r_state <= S_PRE;
`endif
                    end
                end
                S_PRE: begin
                    // Pre-rotate by +/-90 so the residual fits CORDIC convergence range
                    if (r_z > ANG_90) begin
                        r_x <= '0;
                        r_y <= r_x;
                        r_z <= r_z - ANG_90;
                    end else if (r_z < NEG_ANG_90) begin
                        r_x <= '0;
                        r_y <= -r_x;
                        r_z <= r_z + ANG_90;
                    end
                    r_i     <= '0;
                    r_state <= S_ROT;
                end
                S_ROT: begin
                    r_x <= w_rx;
                    r_y <= w_ry;
                    r_z <= w_rz;
                    r_i <= r_i + 3'd1;
                    if (r_i == 3'(ITER - 1)) begin
                        r_state <= S_SCALE;
                    end
                end
                S_SCALE: begin
                    r_x_out     <= sat_w(w_qx);
                    r_y_out     <= sat_w(w_qy);
                    r_out_valid <= 1'b1;
`ifdef CORDIC_ANGERR_EN
                    r_ang_err   <= r_err;
`endif
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
`ifdef CORDIC_ANGERR_EN
                        r_ang_err   <= 1'b0;
`endif
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_polar2rect.sv
// Self-checking bench for cordic_polar2rect: integer reference of the CORDIC rules,
// real-valued cos/sin tolerance checks on directed cases, and a random back-to-back stream.
module tb_cordic_polar2rect;

    localparam int W    = 16;
    localparam int ITER = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    int ATAN_REF [8] = '{4500, 2657, 1404, 713, 358, 179, 89, 44};

    typedef struct {
        int x;
        int y;
        bit err;
        int acc;
    } exp_t;
    exp_t exp_q[$];
    bit   prev_ov = 1'b0;

    cordic_polar2rect_if #(.W(W)) bus ();

    cordic_polar2rect #(.W(W), .ITER(ITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int expv);
        n_cmp++;
        if (got != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    task automatic chk_tol(input string name, input int got, input real expv, input int r);
        real tol;
        real d;
        tol = 0.01 * ((r < 0) ? -r : r) + 2.0;
        d = real'(got) - expv;
        if (d < 0.0) d = -d;
        n_cmp++;
        if (d > tol) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0.1f +/- %0.1f", name, got, expv, tol);
        end
    endtask

    task automatic chk_polar(input string name, input int rx, input int ry, input int r, input int ang);
        real a;
        a = real'(ang) * 3.14159265358979 / 18000.0;
        chk_tol({name, "_x"}, rx, real'(r) * $cos(a), r);
        chk_tol({name, "_y"}, ry, real'(r) * $sin(a), r);
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: fold/pre-rotate, ITER integer micro-rotations, 607/1000 gain, saturate
    function automatic void model(input int r, input int ang, output int ex, output int ey, output bit err);
        int x, y, z, t;
        err = 1'b0;
`ifdef CORDIC_ANGERR_EN
        if (ang > 18000 || ang < -18000) begin
            ex = 0;
            ey = 0;
            err = 1'b1;
            return;
        end
`else
        if (ang > 18000) ang = ang - 36000;
        else if (ang < -18000) ang = ang + 36000;
`endif
        x = r;
        y = 0;
        z = ang;
        if (z > 9000) begin
            y = x; x = 0; z = z - 9000;
        end else if (z < -9000) begin
            y = -x; x = 0; z = z + 9000;
        end
        for (int i = 0; i < ITER; i++) begin
            t = x;
            if (z >= 0) begin
                x = x - (y >>> i);
                y = y + (t >>> i);
                z = z - ATAN_REF[i];
            end else begin
                x = x + (y >>> i);
                y = y - (t >>> i);
                z = z + ATAN_REF[i];
            end
        end
        ex = sat16((607 * x) / 1000);
        ey = sat16((607 * y) / 1000);
    endfunction

    // Scoreboard: record accepted operands, check every valid output cycle
    always @(negedge clk) begin : mon
        exp_t e;
        int   ex, ey;
        bit   er;
        if (rst) begin
            exp_q.delete();
            prev_ov = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                model(int'(bus.r_in), int'(bus.ang_in), ex, ey, er);
                e.x = ex; e.y = ey; e.err = er; e.acc = cyc + 1;
                exp_q.push_back(e);
            end
            if (bus.in_ready && bus.out_valid) begin
                chk("ready_valid_overlap", 1, 0);
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("x_out", int'(bus.x_out), e.x);
                    chk("y_out", int'(bus.y_out), e.y);
`ifdef CORDIC_ANGERR_EN
                    chk("ang_err", int'(bus.ang_err), int'(e.err));
`endif
                    if (!prev_ov && !e.err) chk("latency", cyc - e.acc, ITER + 2);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    task automatic run_op(input int r, input int ang, input int hold, input bit poke,
                          output int rx, output int ry);
        int k;
        @(negedge clk);
        bus.r_in      = W'(r);
        bus.ang_in    = 16'(ang);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        k = 0;
        while (!bus.in_ready && k < 50) begin @(negedge clk); k++; end
        if (k == 50) chk("accept_timeout", 1, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 40) begin @(negedge clk); k++; end
        if (k == 40) chk("out_valid_timeout", 1, 0);
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                bus.in_valid = 1'b1;
                bus.r_in     = W'(1234);
                bus.ang_in   = 16'(-2000);
            end
            chk("hold_in_ready", int'(bus.in_ready), 0);
            @(negedge clk);
        end
        rx = int'(bus.x_out);
        ry = int'(bus.y_out);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("release_in_ready", int'(bus.in_ready), 1);
        chk("release_out_valid", int'(bus.out_valid), 0);
    endtask

    function automatic int rand_ang();
`ifdef CORDIC_ANGERR_EN
        return int'($urandom_range(36000)) - 18000;
`else
        if ($urandom_range(9) == 0) return int'($urandom_range(65535)) - 32768;
        return int'($urandom_range(36000)) - 18000;
`endif
    endfunction

    initial begin : main
        int rx, ry, ex, ey, k, n, guard;
        bit er;
        int acc [20];

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.r_in      = '0;
        bus.ang_in    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_x_out", int'(bus.x_out), 0);
        chk("rst_y_out", int'(bus.y_out), 0);
        rst = 1'b0;

        // Hand-computed pins for the reference model
        model(1000, 0, ex, ey, er);
        chk("model_x_1000_0", ex, 999);
        chk("model_y_1000_0", ey, 6);
        model(0, 7000, ex, ey, er);
        chk("model_x_zero_r", ex, 0);

        // Directed quadrant cases
        run_op(1000, 0, 0, 1'b0, rx, ry);       chk_polar("ang0", rx, ry, 1000, 0);
        run_op(1000, 9000, 0, 1'b0, rx, ry);    chk_polar("ang9000", rx, ry, 1000, 9000);
        run_op(1000, -13500, 0, 1'b0, rx, ry);  chk_polar("angm13500", rx, ry, 1000, -13500);
        run_op(1000, 18000, 0, 1'b0, rx, ry);   chk_polar("ang18000", rx, ry, 1000, 18000);

        // Back-pressure: result held, no new operand accepted
        run_op(700, 4500, 5, 1'b1, rx, ry);     chk_polar("hold", rx, ry, 700, 4500);

        // Async reset in the middle of ROT (i=3)
        @(negedge clk);
        bus.r_in = W'(1000); bus.ang_in = 16'(6000); bus.in_valid = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", int'(bus.out_valid), 0);
        chk("arst_x_out", int'(bus.x_out), 0);
        chk("arst_y_out", int'(bus.y_out), 0);
        chk("arst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(500, 3000, 0, 1'b0, rx, ry);     chk_polar("after_rst", rx, ry, 500, 3000);

        // Out-of-range angle
        run_op(1000, 20000, 0, 1'b0, rx, ry);
`ifdef CORDIC_ANGERR_EN
        chk("angerr_x", rx, 0);
        chk("angerr_y", ry, 0);
`else
        chk_polar("fold20000", rx, ry, 1000, -16000);
`endif

        // Extremes of the input range (exact compare by scoreboard)
        run_op(32767, 4500, 0, 1'b0, rx, ry);
        run_op(-32768, -18000, 0, 1'b0, rx, ry);
        run_op(-32768, 1000, 0, 1'b0, rx, ry);

        // Back-to-back random stream
        @(negedge clk);
        bus.r_in      = W'(int'($urandom_range(65535)) - 32768);
        bus.ang_in    = 16'(rand_ang());
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        n = 0;
        guard = 0;
        while (n < 20 && guard < 2000) begin
            if (bus.in_ready) begin
                acc[n] = cyc + 1;
                n++;
                @(negedge clk);
                bus.r_in   = W'(int'($urandom_range(65535)) - 32768);
                bus.ang_in = 16'(rand_ang());
            end else begin
                @(negedge clk);
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        chk("stream_ops", n, 20);
        for (int i = 1; i < n; i++) chk("init_interval", acc[i] - acc[i-1], ITER + 4);
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin @(negedge clk); k++; end
        chk("drain_pending", exp_q.size(), 0);
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
